imem_arbiter: RTL and testbench

- Shares the single read port of the 4096x32 instruction ROM between two requesters: CPU fetch (port F) and the debug/loader readback path (port D).
- ROM has registered address and unregistered q, so read data is valid the cycle after the address is presented.
- Sits between the fetch stage, the debug unit and the imem instance. Drives imem's address input and returns q to whichever requester owns the in-flight read.

---
 rtl/imem_arb_pkg.sv | 18 +
 rtl/imem_arbiter.sv | 120 ++++++++++++
 tb/tb_imem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-ROM read port and its arbiter.
// Also used by the fetch stage and the debug unit for address/data widths.
package imem_arb_pkg;

  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DEBUG = 2'd2
  } owner_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Two-port (fetch / debug) arbiter for the single read port of the instruction ROM.
// Optional grant/conflict statistics are enabled with `define IMEM_ARBITER_STATS_EN.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DATA_W     = IMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_q,
`ifdef IMEM_ARBITER_STATS_EN
  input  logic              stat_clear,
  output logic [15:0]       stat_f_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_conflicts,
`endif
  output owner_e            dbg_owner_o,
  output logic [3:0]        dbg_starve_cnt_o
);

  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [3:0]        starve_q, starve_d;
  logic              grant_f, grant_d;

  // Handshake: a request transfers in a cycle where valid & ready are both high.
  // A refused requester keeps valid/addr stable; nothing is queued here. The
  // response appears exactly one cycle later and cannot be stalled.
  always_comb begin
    grant_f     = 1'b0;
    grant_d     = 1'b0;
    owner_d     = OWN_NONE;
    starve_d    = 4'd0;
    last_addr_d = last_addr_q;

    if (d_req_valid && (starve_q == STARVE_C)) begin
      grant_d = 1'b1;
    end else if (f_req_valid) begin
      grant_f = 1'b1;
    end else if (d_req_valid) begin
      grant_d = 1'b1;
    end

    if (grant_d) begin
      owner_d     = OWN_DEBUG;
      last_addr_d = d_req_addr;
    end else if (grant_f) begin
      owner_d     = OWN_FETCH;
      last_addr_d = f_req_addr;
    end

    if (d_req_valid && !grant_d) begin
      starve_d = (starve_q < STARVE_C) ? starve_q + 4'd1 : starve_q;
    end
  end

  // Idle cycles keep the ROM on the last address instead of re-addressing it.
  assign mem_address = last_addr_d;
  assign f_req_ready = grant_f;
  assign d_req_ready = grant_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= OWN_NONE;
      last_addr_q <= '0;
      starve_q    <= 4'd0;
    end else begin
      owner_q     <= owner_d;
      last_addr_q <= last_addr_d;
      starve_q    <= starve_d;
    end
  end

  assign f_rsp_valid      = (owner_q == OWN_FETCH);
  assign d_rsp_valid      = (owner_q == OWN_DEBUG);
  assign f_rsp_data       = f_rsp_valid ? mem_q : '0;
  assign d_rsp_data       = d_rsp_valid ? mem_q : '0;
  assign dbg_owner_o      = owner_q;
  assign dbg_starve_cnt_o = starve_q;

`ifdef IMEM_ARBITER_STATS_EN
  logic [15:0] stat_f_q, stat_d_q, stat_c_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_f_q <= 16'd0;
      stat_d_q <= 16'd0;
      stat_c_q <= 16'd0;
    end else if (stat_clear) begin
      stat_f_q <= 16'd0;
      stat_d_q <= 16'd0;
      stat_c_q <= 16'd0;
    end else begin
      if (grant_f) stat_f_q <= sat_inc16(stat_f_q);
      if (grant_d) stat_d_q <= sat_inc16(stat_d_q);
      if (f_req_valid && d_req_valid) stat_c_q <= sat_inc16(stat_c_q);
    end
  end

  assign stat_f_grants  = stat_f_q;
  assign stat_d_grants  = stat_d_q;
  assign stat_conflicts = stat_c_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter against a cycle-level reference of the grant rules.
// Define IMEM_ARBITER_STATS_EN to also check the statistics counters.
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SM = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          f_req_valid = 1'b0, d_req_valid = 1'b0;
  logic [AW-1:0] f_req_addr = '0, d_req_addr = '0;
  logic          f_req_ready, f_rsp_valid, d_req_ready, d_rsp_valid;
  logic [DW-1:0] f_rsp_data, d_rsp_data, mem_q;
  logic [AW-1:0] mem_address;
  owner_e        dbg_owner;
  logic [3:0]    dbg_starve;
`ifdef IMEM_ARBITER_STATS_EN
  logic          stat_clear = 1'b0;
  logic [15:0]   stat_f_grants, stat_d_grants, stat_conflicts;
`endif

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_address(mem_address), .mem_q(mem_q),
`ifdef IMEM_ARBITER_STATS_EN
    .stat_clear(stat_clear), .stat_f_grants(stat_f_grants),
    .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts),
`endif
    .dbg_owner_o(dbg_owner), .dbg_starve_cnt_o(dbg_starve)
  );

  // ROM with registered address and combinational q.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, 8'hA5, ~a};
  endfunction

  logic [AW-1:0] rom_addr_q = '0;
  always @(posedge clock) rom_addr_q <= mem_address;
  assign mem_q = rom_word(rom_addr_q);

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_own  = 0;   // 0 none, 1 fetch, 2 debug: who receives next cycle's data
  int            m_wait = 0;   // consecutive cycles D has been refused
  logic [AW-1:0] m_last = '0;
  logic [DW-1:0] exp_q[$];
`ifdef IMEM_ARBITER_STATS_EN
  int m_fg = 0, m_dg = 0, m_cf = 0;
`endif

  task automatic model_reset();
    m_own  = 0;
    m_wait = 0;
    m_last = '0;
    exp_q.delete();
`ifdef IMEM_ARBITER_STATS_EN
    m_fg = 0; m_dg = 0; m_cf = 0;
`endif
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic fv, input logic [AW-1:0] fa,
                      input logic dv, input logic [AW-1:0] da,
                      input logic clr, output logic gf, output logic gd);
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    @(negedge clock);
    ed = (m_own != 0 && exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("f_rsp_valid", f_rsp_valid, m_own == 1);
    check("d_rsp_valid", d_rsp_valid, m_own == 2);
    check("f_rsp_data", f_rsp_data, (m_own == 1) ? ed : '0);
    check("d_rsp_data", d_rsp_data, (m_own == 2) ? ed : '0);
    check("owner", 32'(dbg_owner), m_own);
`ifdef IMEM_ARBITER_STATS_EN
    check("stat_f", stat_f_grants, m_fg);
    check("stat_d", stat_d_grants, m_dg);
    check("stat_conf", stat_conflicts, m_cf);
    stat_clear = clr;
`endif
    f_req_valid = fv; f_req_addr = fa;
    d_req_valid = dv; d_req_addr = da;
    #1;
    gd = dv && (m_wait == SM);
    gf = !gd && fv;
    gd = gd || (!gf && dv);
    ea = gd ? da : (gf ? fa : m_last);
    check("f_req_ready", f_req_ready, gf);
    check("d_req_ready", d_req_ready, gd);
    check("mem_address", mem_address, ea);
    check("starve_cnt", dbg_starve, m_wait);
    m_own  = gd ? 2 : (gf ? 1 : 0);
    if (gf || gd) exp_q.push_back(rom_word(ea));
    m_last = ea;
    m_wait = (dv && !gd) ? ((m_wait < SM) ? m_wait + 1 : m_wait) : 0;
`ifdef IMEM_ARBITER_STATS_EN
    if (clr) begin
      m_fg = 0; m_dg = 0; m_cf = 0;
    end else begin
      if (gf && m_fg < 65535) m_fg++;
      if (gd && m_dg < 65535) m_dg++;
      if (fv && dv && m_cf < 65535) m_cf++;
    end
`else
    if (clr) m_wait = m_wait;
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic          gf, gd, fv, dv;
    logic [AW-1:0] fa, da;
    gf = 0; gd = 0; fv = 0; dv = 0; fa = '0; da = '0;

    repeat (3) @(negedge clock);
    check("rst_f_rsp_valid", f_rsp_valid, 0);
    check("rst_d_rsp_valid", d_rsp_valid, 0);
    check("rst_owner", 32'(dbg_owner), 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_f_rsp_data", f_rsp_data, 0);
    reset_n = 1'b1;
    model_reset();

    // fetch only, consecutive addresses
    for (int i = 0; i < 3; i++) step(1, AW'(i), 0, 0, 0, gf, gd);
    // conflict on 10 / 20: D forced through after STARVE_MAX refusals
    step(0, 0, 0, 0, 1, gf, gd);
    for (int i = 0; i < 6; i++) begin
      step(1, 12'd10, 1, 12'd20, 0, gf, gd);
      check("conflict_d_grant", gd, i == SM);
    end
`ifdef IMEM_ARBITER_STATS_EN
    step(0, 0, 0, 0, 1, gf, gd);
    check("stat_conf_six", stat_conflicts, 6);
    check("stat_f_five", stat_f_grants, 5);
    check("stat_d_one", stat_d_grants, 1);
`endif
    // debug only, top address then zero
    step(0, 0, 1, 12'd4095, 0, gf, gd);
    step(0, 0, 1, 12'd0, 0, gf, gd);
    // idle after a fetch of 7
    step(1, 12'd7, 0, 0, 0, gf, gd);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, gf, gd);
      check("idle_hold_addr", mem_address, 7);
    end
    // same address on both ports is serialized
    step(1, 12'd99, 1, 12'd99, 0, gf, gd);
    step(0, 0, 1, 12'd99, 0, gf, gd);

    // reset while a debug read is in flight
    step(0, 0, 1, 12'd33, 0, gf, gd);
    @(negedge clock);
    reset_n = 1'b0;
    f_req_valid = 0; d_req_valid = 0;
    #1;
    check("midrst_d_rsp_valid", d_rsp_valid, 0);
    check("midrst_owner", 32'(dbg_owner), 0);
    check("midrst_d_rsp_data", d_rsp_data, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, gf, gd);
    step(0, 0, 0, 0, 0, gf, gd);

    // randomized traffic; refused requesters usually hold, sometimes drop
    fv = 0; dv = 0; gf = 0; gd = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(fv && !gf) || $urandom_range(0, 15) == 0) begin
        fv = ($urandom_range(0, 3) != 0);
        fa = AW'($urandom_range(0, 4095));
      end
      if (!(dv && !gd) || $urandom_range(0, 15) == 0) begin
        dv = ($urandom_range(0, 1) != 0);
        da = ($urandom_range(0, 7) == 0) ? fa : AW'($urandom_range(0, 4095));
      end
      step(fv, fa, dv, da, ($urandom_range(0, 63) == 0), gf, gd);
    end
    step(0, 0, 0, 0, 0, gf, gd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
